// File: rtl/hpdcache_flush_mc_controller.sv
// Multi-entry flush directory: buffers evicted dirty lines, streams each one to memory as
// a write request plus a data burst, and keeps it checkable until its write response returns.
//
//   state | meaning
//   IDLE  | waiting for a queued entry; pops the send queue head when non-empty
//   REQ   | write request presented for the current entry
//   DATA  | streaming the current entry's beats, one per data handshake
module hpdcache_flush_mc_controller #(
    parameter int N_ENTRIES  = 4,
    parameter int NLINE_W    = 26,
    parameter int OFFSET_W   = 6,
    parameter int LINE_W     = 512,
    parameter int MEM_DATA_W = 64,
    parameter int MEM_ID_W   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    output logic                         flush_empty_o,
    output logic                         flush_full_o,
    output logic                         flush_busy_o,
    input  logic                         flush_check_i,
    input  logic [NLINE_W-1:0]           flush_check_nline_i,
    output logic                         flush_check_hit_o,
    input  logic                         flush_alloc_i,
    input  logic [NLINE_W-1:0]           flush_alloc_nline_i,
    input  logic [LINE_W-1:0]            flush_alloc_data_i,
    input  logic                         mem_req_write_ready_i,
    output logic                         mem_req_write_valid_o,
    output logic [NLINE_W+OFFSET_W-1:0]  mem_req_write_addr_o,
    output logic [7:0]                   mem_req_write_len_o,
    output logic [MEM_ID_W-1:0]          mem_req_write_id_o,
    input  logic                         mem_req_write_data_ready_i,
    output logic                         mem_req_write_data_valid_o,
    output logic [MEM_DATA_W-1:0]        mem_req_write_data_o,
    output logic                         mem_req_write_data_last_o,
    output logic                         mem_resp_write_ready_o,
    input  logic                         mem_resp_write_valid_i,
    input  logic [MEM_ID_W-1:0]          mem_resp_write_id_i
);
    localparam int BEATS  = LINE_W / MEM_DATA_W;
    localparam int IDX_W  = $clog2(N_ENTRIES);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_e;

    logic [N_ENTRIES-1:0] valid_q, sent_q;
    logic [NLINE_W-1:0]   nline_q [N_ENTRIES];
    logic [LINE_W-1:0]    data_q  [N_ENTRIES];
    logic [IDX_W-1:0]     sq_mem  [N_ENTRIES];
    logic [IDX_W-1:0]     sq_head, sq_tail;
    logic [CNT_W-1:0]     sq_cnt;
    state_e               state_q;
    logic [IDX_W-1:0]     cur_idx;
    logic [BEAT_W-1:0]    beat_q;

    logic             alloc_accept, alloc_found, sq_pop, check_match, resp_ok;
    logic [IDX_W-1:0] alloc_idx, resp_idx;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(N_ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [MEM_DATA_W-1:0] beat_of(input logic [LINE_W-1:0] line, input int k);
        return line[k*MEM_DATA_W +: MEM_DATA_W];
    endfunction

    assign flush_empty_o          = ~|valid_q;
    assign flush_full_o           = &valid_q;
    assign flush_busy_o           = (state_q != IDLE) | (|valid_q);
    assign mem_req_write_len_o    = 8'(BEATS - 1);
    assign mem_resp_write_ready_o = 1'b1;

    // Decisions use registered valid bits only, so a slot freed this cycle is reusable next cycle.
    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx   = IDX_W'(i);
                alloc_found = 1'b1;
            end
        end
        check_match = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (valid_q[i] && (nline_q[i] == flush_check_nline_i)) check_match = 1'b1;
        end
    end

    assign flush_check_hit_o = flush_check_i & check_match;
    assign alloc_accept      = flush_alloc_i & alloc_found;
    assign sq_pop            = (state_q == IDLE) && (sq_cnt != '0);
    assign resp_idx          = mem_resp_write_id_i[IDX_W-1:0];
    assign resp_ok           = mem_resp_write_valid_i && (int'(mem_resp_write_id_i) < N_ENTRIES)
                               && valid_q[resp_idx] && sent_q[resp_idx];

    always_ff @(posedge clk_i) begin
        if (alloc_accept) begin
            sq_mem[sq_tail]    <= alloc_idx;
            nline_q[alloc_idx] <= flush_alloc_nline_i;
            data_q[alloc_idx]  <= flush_alloc_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q                    <= '0;
            sent_q                     <= '0;
            sq_head                    <= '0;
            sq_tail                    <= '0;
            sq_cnt                     <= '0;
            state_q                    <= IDLE;
            cur_idx                    <= '0;
            beat_q                     <= '0;
            mem_req_write_valid_o      <= 1'b0;
            mem_req_write_addr_o       <= '0;
            mem_req_write_id_o         <= '0;
            mem_req_write_data_valid_o <= 1'b0;
            mem_req_write_data_o       <= '0;
            mem_req_write_data_last_o  <= 1'b0;
        end else begin
            if (mem_resp_write_valid_i) begin
                assert (resp_ok) else $error("write response for idle or unsent entry id %0d", mem_resp_write_id_i);
            end
            if (resp_ok) valid_q[resp_idx] <= 1'b0;
            if (alloc_accept) begin
                valid_q[alloc_idx] <= 1'b1;
                sent_q[alloc_idx]  <= 1'b0;
                sq_tail            <= wrap_inc(sq_tail);
            end
            if (alloc_accept && !sq_pop) sq_cnt <= sq_cnt + 1'b1;
            else if (!alloc_accept && sq_pop) sq_cnt <= sq_cnt - 1'b1;

            case (state_q)
                IDLE: begin
                    if (sq_pop) begin
                        cur_idx               <= sq_mem[sq_head];
                        sq_head               <= wrap_inc(sq_head);
                        mem_req_write_valid_o <= 1'b1;
                        mem_req_write_addr_o  <= {nline_q[sq_mem[sq_head]], {OFFSET_W{1'b0}}};
                        mem_req_write_id_o    <= MEM_ID_W'(sq_mem[sq_head]);
                        state_q               <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_write_ready_i) begin
                        mem_req_write_valid_o      <= 1'b0;
                        mem_req_write_data_valid_o <= 1'b1;
                        mem_req_write_data_o       <= beat_of(data_q[cur_idx], 0);
                        mem_req_write_data_last_o  <= (BEATS == 1);
                        beat_q                     <= '0;
                        state_q                    <= DATA;
                    end
                end
                DATA: begin
                    if (mem_req_write_data_ready_i) begin
                        if (mem_req_write_data_last_o) begin
                            sent_q[cur_idx]            <= 1'b1;
                            mem_req_write_data_valid_o <= 1'b0;
                            mem_req_write_data_last_o  <= 1'b0;
                            state_q                    <= IDLE;
                        end else begin
                            beat_q                    <= beat_q + 1'b1;
                            mem_req_write_data_o      <= beat_of(data_q[cur_idx], int'(beat_q) + 1);
                            mem_req_write_data_last_o <= (int'(beat_q) + 1 == BEATS - 1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hpdcache_flush_mc_controller.sv
// Bench for the multi-entry flush controller: directed scenarios plus random traffic,
// checked against an entry/queue model of the flush directory.
module tb_hpdcache_flush_mc_controller;
    localparam int N       = 4;
    localparam int NLINE_W = 26;
    localparam int OFF_W   = 6;
    localparam int LINE_W  = 512;
    localparam int DW      = 64;
    localparam int IDW     = 4;
    localparam int BEATS   = LINE_W / DW;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               flush_empty_o, flush_full_o, flush_busy_o;
    logic               flush_check_i;
    logic [NLINE_W-1:0] flush_check_nline_i;
    logic               flush_check_hit_o;
    logic               flush_alloc_i;
    logic [NLINE_W-1:0] flush_alloc_nline_i;
    logic [LINE_W-1:0]  flush_alloc_data_i;
    logic               mem_req_write_ready_i, mem_req_write_valid_o;
    logic [NLINE_W+OFF_W-1:0] mem_req_write_addr_o;
    logic [7:0]         mem_req_write_len_o;
    logic [IDW-1:0]     mem_req_write_id_o;
    logic               mem_req_write_data_ready_i, mem_req_write_data_valid_o;
    logic [DW-1:0]      mem_req_write_data_o;
    logic               mem_req_write_data_last_o;
    logic               mem_resp_write_ready_o, mem_resp_write_valid_i;
    logic [IDW-1:0]     mem_resp_write_id_i;

    hpdcache_flush_mc_controller #(
        .N_ENTRIES(N), .NLINE_W(NLINE_W), .OFFSET_W(OFF_W),
        .LINE_W(LINE_W), .MEM_DATA_W(DW), .MEM_ID_W(IDW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .flush_empty_o(flush_empty_o), .flush_full_o(flush_full_o), .flush_busy_o(flush_busy_o),
        .flush_check_i(flush_check_i), .flush_check_nline_i(flush_check_nline_i),
        .flush_check_hit_o(flush_check_hit_o),
        .flush_alloc_i(flush_alloc_i), .flush_alloc_nline_i(flush_alloc_nline_i),
        .flush_alloc_data_i(flush_alloc_data_i),
        .mem_req_write_ready_i(mem_req_write_ready_i), .mem_req_write_valid_o(mem_req_write_valid_o),
        .mem_req_write_addr_o(mem_req_write_addr_o), .mem_req_write_len_o(mem_req_write_len_o),
        .mem_req_write_id_o(mem_req_write_id_o),
        .mem_req_write_data_ready_i(mem_req_write_data_ready_i),
        .mem_req_write_data_valid_o(mem_req_write_data_valid_o),
        .mem_req_write_data_o(mem_req_write_data_o), .mem_req_write_data_last_o(mem_req_write_data_last_o),
        .mem_resp_write_ready_o(mem_resp_write_ready_o), .mem_resp_write_valid_i(mem_resp_write_valid_i),
        .mem_resp_write_id_i(mem_resp_write_id_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one record per directory slot plus the allocation-order send list.
    logic               m_valid [N];
    logic               m_sent  [N];
    logic [NLINE_W-1:0] m_nline [N];
    logic [LINE_W-1:0]  m_data  [N];
    int                 sendq [$];
    int                 m_cur, m_beat, n_sent;
    bit                 m_burst;
    bit                 req_stall, data_stall;
    logic [31:0]        s_addr;
    logic [IDW-1:0]     s_id;
    logic [DW-1:0]      s_data;
    logic               s_last;

    task automatic chk(input logic [63:0] got, input logic [63:0] exp, input string tag);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic bit m_hit();
        if (!flush_check_i) return 1'b0;
        for (int i = 0; i < N; i++) if (m_valid[i] && m_nline[i] == flush_check_nline_i) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0; m_sent[i] = 1'b0; m_nline[i] = '0; m_data[i] = '0;
        end
        sendq.delete();
        m_burst = 1'b0; m_beat = 0; m_cur = 0;
        req_stall = 1'b0; data_stall = 1'b0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic cyc();
        int idx, fr;
        bit full_before;
        logic [LINE_W-1:0] sh;
        @(negedge clk_i);
        chk(64'(flush_empty_o), 64'(m_count() == 0), "empty");
        chk(64'(flush_full_o), 64'(m_count() == N), "full");
        chk(64'(flush_busy_o), 64'(m_count() != 0 || m_burst), "busy");
        chk(64'(flush_check_hit_o), 64'(m_hit()), "check_hit");
        if (req_stall) begin
            chk(64'(mem_req_write_valid_o), 64'(1), "req_hold_valid");
            chk(64'(mem_req_write_addr_o), 64'(s_addr), "req_hold_addr");
            chk(64'(mem_req_write_id_o), 64'(s_id), "req_hold_id");
        end
        if (data_stall) begin
            chk(64'(mem_req_write_data_valid_o), 64'(1), "data_hold_valid");
            chk(64'(mem_req_write_data_o), 64'(s_data), "data_hold_data");
            chk(64'(mem_req_write_data_last_o), 64'(s_last), "data_hold_last");
        end
        req_stall  = mem_req_write_valid_o && !mem_req_write_ready_i;
        data_stall = mem_req_write_data_valid_o && !mem_req_write_data_ready_i;
        s_addr = 32'(mem_req_write_addr_o); s_id = mem_req_write_id_o;
        s_data = mem_req_write_data_o; s_last = mem_req_write_data_last_o;
        if (mem_req_write_valid_o && mem_req_write_ready_i) begin
            chk(64'(m_burst || sendq.size() == 0), 64'(0), "req_unexpected");
            chk(64'(mem_req_write_len_o), 64'(BEATS - 1), "req_len");
            if (sendq.size() > 0) begin
                idx = sendq.pop_front();
                chk(64'(mem_req_write_addr_o), 64'(32'(m_nline[idx]) * 64), "req_addr");
                chk(64'(mem_req_write_id_o), 64'(idx), "req_id");
                m_cur = idx; m_beat = 0; m_burst = 1'b1;
            end
        end
        if (mem_req_write_data_valid_o && mem_req_write_data_ready_i) begin
            chk(64'(m_burst), 64'(1), "data_without_req");
            if (m_burst) begin
                sh = m_data[m_cur] >> (DW * m_beat);
                chk(64'(mem_req_write_data_o), sh[63:0], "beat_data");
                chk(64'(mem_req_write_data_last_o), 64'(m_beat == BEATS - 1), "beat_last");
                if (m_beat == BEATS - 1) begin
                    m_sent[m_cur] = 1'b1; m_burst = 1'b0; n_sent++;
                end else m_beat++;
            end
        end
        full_before = (m_count() == N);
        fr = m_lowest_free();
        if (mem_resp_write_valid_i) m_valid[mem_resp_write_id_i] = 1'b0;
        if (flush_alloc_i && !full_before) begin
            m_valid[fr] = 1'b1; m_sent[fr] = 1'b0;
            m_nline[fr] = flush_alloc_nline_i; m_data[fr] = flush_alloc_data_i;
            sendq.push_back(fr);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_alloc(input logic [NLINE_W-1:0] nl, input logic [LINE_W-1:0] d);
        flush_alloc_i = 1'b1; flush_alloc_nline_i = nl; flush_alloc_data_i = d;
        cyc();
        flush_alloc_i = 1'b0;
    endtask

    task automatic respond(input int id);
        mem_resp_write_valid_i = 1'b1; mem_resp_write_id_i = IDW'(id);
        cyc();
        mem_resp_write_valid_i = 1'b0;
    endtask

    task automatic wait_sent(input int target, input int budget);
        int c = 0;
        while (n_sent < target && c < budget) begin cyc(); c++; end
        chk(64'(n_sent >= target), 64'(1), "wait_sent_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(64'(flush_empty_o), 64'(1), {tag, "_empty"});
        chk(64'(flush_full_o), 64'(0), {tag, "_full"});
        chk(64'(flush_busy_o), 64'(0), {tag, "_busy"});
        chk(64'(flush_check_hit_o), 64'(0), {tag, "_hit"});
        chk(64'(mem_req_write_valid_o), 64'(0), {tag, "_req_valid"});
        chk(64'(mem_req_write_data_valid_o), 64'(0), {tag, "_data_valid"});
        chk(64'(mem_req_write_data_last_o), 64'(0), {tag, "_last"});
        chk(64'(mem_req_write_len_o), 64'(BEATS - 1), {tag, "_len"});
        chk(64'(mem_resp_write_ready_o), 64'(1), {tag, "_resp_ready"});
        chk(64'(mem_req_write_addr_o), 64'(0), {tag, "_addr"});
        chk(64'(mem_req_write_id_o), 64'(0), {tag, "_id"});
        chk(64'(mem_req_write_data_o), 64'(0), {tag, "_data"});
    endtask

    initial begin
        logic [LINE_W-1:0] asc;
        int base, pick;
        int cand [$];
        for (int b = 0; b < LINE_W / 8; b++) asc[b*8 +: 8] = 8'(b);
        rst_ni = 1'b0;
        flush_check_i = 1'b1; flush_check_nline_i = 26'h123;
        flush_alloc_i = 1'b0; flush_alloc_nline_i = '0; flush_alloc_data_i = '0;
        mem_req_write_ready_i = 1'b1; mem_req_write_data_ready_i = 1'b1;
        mem_resp_write_valid_i = 1'b0; mem_resp_write_id_i = '0;
        n_sent = 0;
        m_reset();
        #12;
        check_reset_outputs("reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Single line, memory always ready.
        do_alloc(26'h123, asc);
        chk(64'(flush_check_hit_o), 64'(1), "t1_hit_next_cycle");
        chk(64'(mem_req_write_valid_o), 64'(0), "t1_req_not_yet");
        cyc();
        chk(64'(mem_req_write_valid_o), 64'(1), "t1_req_valid");
        chk(64'(mem_req_write_addr_o), 64'h48C0, "t1_addr");
        chk(64'(mem_req_write_id_o), 64'(0), "t1_id");
        cyc();
        chk(64'(mem_req_write_data_o), 64'h0706050403020100, "t1_beat0");
        chk(64'(mem_req_write_data_last_o), 64'(0), "t1_beat0_last");
        wait_sent(1, 50);
        chk(64'(flush_check_hit_o), 64'(1), "t1_hit_before_resp");
        respond(0);
        chk(64'(flush_check_hit_o), 64'(0), "t1_hit_after_resp");
        chk(64'(flush_empty_o), 64'(1), "t1_empty");

        // Fill with requests stalled; fifth alloc is dropped.
        mem_req_write_ready_i = 1'b0;
        for (int i = 0; i < N; i++) do_alloc(NLINE_W'($urandom), rand_line());
        chk(64'(flush_full_o), 64'(1), "t2_full");
        do_alloc(NLINE_W'($urandom), rand_line());
        chk(64'(flush_full_o), 64'(1), "t2_full_after_drop");
        for (int i = 0; i < 3; i++) cyc();
        mem_req_write_ready_i = 1'b1;
        base = n_sent;
        wait_sent(base + N, 200);

        // Out-of-order response frees only entry 2, which is reused next.
        respond(2);
        chk(64'(flush_full_o), 64'(0), "t3_full_drop");
        do_alloc(NLINE_W'($urandom), rand_line());
        chk(64'(flush_full_o), 64'(1), "t3_refull");
        wait_sent(n_sent + 1, 50);

        // Response and alloc in the same cycle while full: alloc dropped, retried next cycle.
        mem_resp_write_valid_i = 1'b1; mem_resp_write_id_i = 4'd3;
        flush_alloc_i = 1'b1; flush_alloc_nline_i = NLINE_W'($urandom); flush_alloc_data_i = rand_line();
        cyc();
        mem_resp_write_valid_i = 1'b0; flush_alloc_i = 1'b0;
        chk(64'(flush_full_o), 64'(0), "t4_alloc_dropped");
        do_alloc(NLINE_W'($urandom), rand_line());
        chk(64'(flush_full_o), 64'(1), "t4_entry3_refilled");
        wait_sent(n_sent + 1, 50);
        respond(1); respond(0); respond(3); respond(2);
        chk(64'(flush_empty_o), 64'(1), "t4_empty");

        // Random traffic with stalls on both channels.
        for (int c = 0; c < 600; c++) begin
            mem_req_write_ready_i      = ($urandom_range(0, 2) != 0);
            mem_req_write_data_ready_i = ($urandom_range(0, 2) != 0);
            flush_alloc_i       = ($urandom_range(0, 2) == 0);
            flush_alloc_nline_i = NLINE_W'($urandom);
            flush_alloc_data_i  = rand_line();
            flush_check_i       = ($urandom_range(0, 3) != 0);
            flush_check_nline_i = ($urandom_range(0, 1) == 1) ? m_nline[$urandom_range(0, N - 1)]
                                                               : NLINE_W'($urandom);
            cand.delete();
            for (int i = 0; i < N; i++) if (m_valid[i] && m_sent[i]) cand.push_back(i);
            mem_resp_write_valid_i = 1'b0;
            if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                pick = cand[$urandom_range(0, cand.size() - 1)];
                mem_resp_write_valid_i = 1'b1;
                mem_resp_write_id_i    = IDW'(pick);
            end
            cyc();
        end
        flush_alloc_i = 1'b0; mem_resp_write_valid_i = 1'b0;
        mem_req_write_ready_i = 1'b1; mem_req_write_data_ready_i = 1'b1;
        wait_sent(n_sent + sendq.size() + (m_burst ? 1 : 0), 300);
        for (int i = 0; i < N; i++) if (m_valid[i] && m_sent[i]) respond(i);
        chk(64'(flush_empty_o), 64'(1), "t5_drained_empty");

        // Reset in the middle of a burst.
        do_alloc(NLINE_W'($urandom), rand_line());
        begin
            int c = 0;
            while (!(m_burst && m_beat == 4) && c < 40) begin cyc(); c++; end
            chk(64'(m_burst && m_beat == 4), 64'(1), "t6_reach_beat4");
        end
        chk(64'(mem_req_write_data_valid_o), 64'(1), "t6_mid_burst");
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        m_reset();
        @(posedge clk_i); #1;
        check_reset_outputs("t6_held");
        rst_ni = 1'b1;
        do_alloc(NLINE_W'($urandom), rand_line());
        wait_sent(n_sent + 1, 50);
        respond(0);
        chk(64'(flush_empty_o), 64'(1), "t6_empty");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
